regfile_port_arbiter: RTL

Sequencer and arbiter in front of the CPU `register_file`. It shares the single write port and read port 1 between core writeback and a debug/host request channel. After reset, or on request, it runs a clear sequence that zeroes x1..x31. It stalls the core whenever it takes a port the core needs.

---
 rtl/regfile_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Sits in front of the CPU register_file. It shares the single write port and
// read port 1 between core writeback and a debug/host request channel. After
// reset, or when init_start is pulsed in RUN, it zeroes x1..x(N_REGS-1).
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   init_start        : pulse in RUN restarts the clear sequence
//   core_wr_*         : core writeback request (held while core_stall=1)
//   core_rd_addr1     : core read port 1 address
//   core_stall        : core must hold its state and inputs this cycle
//   dbg_req_*         : debug request channel (valid/ready handshake)
//   dbg_rsp_*         : one-cycle response pulse, read data (0 for writes)
//   clear_busy        : clear sequence in progress
//   rf_wr_*, rf_rd_*  : register_file write port and read port 1
// ----------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int N_REGS       = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  input  logic              core_wr_ena,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic [ADDR_W-1:0] core_rd_addr1,
  output logic              core_stall,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              clear_busy,
  output logic              rf_wr_ena,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  input  logic [DATA_W-1:0] rf_rd_data1
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_FIRST  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(N_REGS - 1);
  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [3:0]          starve_cnt_reg, starve_cnt_next;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;

  logic                dbg_accept;
  logic                dbg_rd_accept;
  logic                dbg_wr_req;
  logic                dbg_rd_req;

  assign dbg_wr_req = dbg_req_valid &  dbg_req_write;
  assign dbg_rd_req = dbg_req_valid & ~dbg_req_write;

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    core_stall      = 1'b0;
    clear_busy      = 1'b0;
    dbg_req_ready   = 1'b0;
    dbg_accept      = 1'b0;
    dbg_rd_accept   = 1'b0;
    rf_wr_ena       = 1'b0;
    rf_wr_addr      = core_wr_addr;
    rf_wr_data      = core_wr_data;
    rf_rd_addr1     = core_rd_addr1;

    case (state_reg)
      CLEAR: begin
        rf_wr_ena       = 1'b1;
        rf_wr_addr      = clr_cnt_reg;
        rf_wr_data      = '0;
        core_stall      = 1'b1;
        clear_busy      = 1'b1;
        starve_cnt_next = '0;
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = RUN;
        end else begin
          clr_cnt_next = clr_cnt_reg + CLR_FIRST;
        end
      end

      default: begin
        if (init_start) begin
          // Nothing is granted on the restart cycle; the core is held so its
          // pending write is not lost.
          state_next      = CLEAR;
          clr_cnt_next    = CLR_FIRST;
          starve_cnt_next = '0;
          core_stall      = 1'b1;
        end else if (dbg_rd_req) begin
          // Debug read steals read port 1; the core is stalled so it neither
          // sees the wrong read data nor writes this cycle.
          dbg_req_ready = 1'b1;
          dbg_accept    = 1'b1;
          dbg_rd_accept = 1'b1;
          rf_rd_addr1   = dbg_req_addr;
          core_stall    = 1'b1;
        end else if (dbg_wr_req) begin
          if (!core_wr_ena || (starve_cnt_reg == STARVE_MAX)) begin
            // Free port, or starvation preempt (core deferred one cycle).
            dbg_req_ready   = 1'b1;
            dbg_accept      = 1'b1;
            core_stall      = core_wr_ena;
            rf_wr_ena       = (dbg_req_addr != '0);
            rf_wr_addr      = dbg_req_addr;
            rf_wr_data      = dbg_req_wdata;
            starve_cnt_next = '0;
          end else begin
            rf_wr_ena = 1'b1;
            if (starve_cnt_reg != STARVE_MAX) begin
              starve_cnt_next = starve_cnt_reg + 4'd1;
            end
          end
        end else begin
          rf_wr_ena = core_wr_ena;
          if (!dbg_req_valid) begin
            starve_cnt_next = '0;
          end
        end
      end
    endcase

    // While reset is held the state register may not be valid yet: keep the
    // write port quiet and the core parked.
    if (!rst_n) begin
      rf_wr_ena     = 1'b0;
      dbg_req_ready = 1'b0;
      dbg_accept    = 1'b0;
      dbg_rd_accept = 1'b0;
      core_stall    = 1'b1;
      clear_busy    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= CLEAR;
      clr_cnt_reg    <= CLR_FIRST;
      starve_cnt_reg <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      rsp_valid_reg  <= dbg_accept;
      rsp_rdata_reg  <= dbg_rd_accept ? rf_rd_data1 : '0;
    end
  end

  assign dbg_rsp_valid = rsp_valid_reg;
  assign dbg_rsp_rdata = rsp_rdata_reg;

endmodule
